dmem_bram_arbiter: RTL and testbench

- Shares the single-port data BRAM (32-bit words, 1-cycle registered read) between two requesters.
- Port 0 is the CPU data-memory path; port 1 is a loader/debug master, e.g. a UART program loader.
- Round-robin arbitration, with an optional bounded lock on port 1 for burst loads.
- Sits between data_memory / loader and the blk_mem_gen BRAM instance; drives bram_en/we/addr/din directly.

---
 rtl/dmem_bram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dmem_bram_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bram_arbiter.sv
// Two-port arbiter in front of the single-port data BRAM: CPU data path on port 0,
// loader/debug master on port 1, round-robin with a bounded burst lock for port 1.
module dmem_bram_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout
);

    localparam int                CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_RR,
        ST_LOCK,
        ST_FORCE
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;      // 0: port 0 preferred on contention
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_at_max;

    logic             gnt0, gnt1;
    logic             oor0, oor1;
    logic             sel_oor;

    logic             rvalid0_q, rvalid1_q;
    logic             zero0_q, zero1_q;
    logic [31:0]      rdata0_q, rdata1_q;
    logic [31:0]      rdata0_live, rdata1_live;

    // Byte-offset bits never reach the BRAM; lanes come from the write enables.
    logic             unused_byte_offset;
    assign unused_byte_offset = ^{m0_addr[1:0], m1_addr[1:0]};

    assign oor0       = |m0_addr[31:ADDR_W+2];
    assign oor1       = |m1_addr[31:ADDR_W+2];
    assign cnt_at_max = (cnt_q == CNT_MAX);

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        case (state_q)
            ST_RR: begin
                if (m0_req && m1_req) begin
                    gnt0 = ~ptr_q;
                    gnt1 = ptr_q;
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
                if (gnt0) ptr_d = 1'b1;
                if (gnt1) begin
                    ptr_d = 1'b0;
                    if (m1_lock) begin
                        state_d = ST_LOCK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end

            ST_LOCK: begin
                // A saturated count yields the slot to a waiting port 0 instead.
                gnt1 = m1_req && !(cnt_at_max && m0_req);
                if (gnt1 && !cnt_at_max) cnt_d = cnt_q + CNT_W'(1);
                if (!m1_lock) begin
                    state_d = ST_RR;
                    ptr_d   = 1'b0;
                end else if (cnt_at_max && m0_req) begin
                    state_d = ST_FORCE;
                end
            end

            ST_FORCE: begin
                gnt0 = m0_req;
                if (gnt0) ptr_d = 1'b1;
                if (m1_lock) begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RR;
                end
            end

            default: state_d = ST_RR;
        endcase

        // Grants are combinational, so they must be suppressed while reset is held.
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;
    assign m0_err = gnt0 && oor0;
    assign m1_err = gnt1 && oor1;

    assign sel_oor   = gnt1 ? oor1 : oor0;
    assign bram_en   = (gnt0 || gnt1) && !sel_oor;
    assign bram_we   = bram_en ? (gnt1 ? m1_we : m0_we) : 4'h0;
    assign bram_addr = gnt1 ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
    assign bram_din  = gnt1 ? m1_wdata : m0_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RR;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            zero0_q   <= 1'b0;
            zero1_q   <= 1'b0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0 && (m0_we == 4'h0);
            rvalid1_q <= gnt1 && (m1_we == 4'h0);
            zero0_q   <= oor0;
            zero1_q   <= oor1;
            if (rvalid0_q) rdata0_q <= rdata0_live;
            if (rvalid1_q) rdata1_q <= rdata1_live;
        end
    end

    // BRAM data arrives in the rvalid cycle; the held copy covers the idle cycles.
    assign rdata0_live = zero0_q ? 32'h0 : bram_dout;
    assign rdata1_live = zero1_q ? 32'h0 : bram_dout;

    assign m0_rvalid = rvalid0_q && !rst;
    assign m1_rvalid = rvalid1_q && !rst;
    assign m0_rdata  = m0_rvalid ? rdata0_live : rdata0_q;
    assign m1_rdata  = m1_rvalid ? rdata1_live : rdata1_q;

endmodule

// File: tb/tb_dmem_bram_arbiter.sv
// Directed bench for dmem_bram_arbiter with a behavioural 32-word BRAM behind it.
module tb_dmem_bram_arbiter;

    localparam int ADDR_W   = 5;
    localparam int LOCK_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req, m1_lock;
    logic [3:0]        m0_we, m1_we;
    logic [31:0]       m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0]       m0_rdata, m1_rdata;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic [31:0]       bram_dout = 32'h0;
    logic [31:0]       mem [0:(1<<ADDR_W)-1] = '{default: 32'h0};

    int n_checks = 0;
    int n_pass   = 0;

    dmem_bram_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    // Single-port BRAM, byte-lane writes, one-cycle registered read.
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
            if (bram_we == 4'h0) bram_dout <= mem[bram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    endtask

    // Grant code per cycle: 0 none, 1 port 0, 2 port 1.
    logic [1:0] lock_exp [0:12] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1,
                                    2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};

    initial begin
        rst = 1'b1;
        set_m0(1'b1, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Reset held with a pending port-0 request
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_m0_gnt",    32'(m0_gnt),    0);
            check("rst_m1_gnt",    32'(m1_gnt),    0);
            check("rst_m0_rvalid", 32'(m0_rvalid), 0);
            check("rst_bram_en",   32'(bram_en),   0);
        end
        step(); rst = 1'b0;
        @(negedge clk);
        check("rel_m0_gnt", 32'(m0_gnt), 1);

        // Port-0 write then read back
        step(); set_m0(1'b1, 4'hF, 32'h0C, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_m0_gnt",    32'(m0_gnt),    1);
        check("wr_bram_en",   32'(bram_en),   1);
        check("wr_bram_we",   32'(bram_we),   32'hF);
        check("wr_bram_addr", 32'(bram_addr), 3);
        check("wr_bram_din",  bram_din,       32'hDEADBEEF);
        check("rel_rvalid",   32'(m0_rvalid), 1);
        check("rel_rdata",    m0_rdata,       0);
        step(); set_m0(1'b1, 4'h0, 32'h0C, 32'h0);
        @(negedge clk);
        check("rd_m0_gnt",   32'(m0_gnt),    1);
        check("rd_bram_we",  32'(bram_we),   0);
        check("wr_no_rvalid", 32'(m0_rvalid), 0);
        step(); set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("rd_m0_rvalid", 32'(m0_rvalid), 1);
        check("rd_m0_rdata",  m0_rdata,       32'hDEADBEEF);

        // Port-1 write to word 4
        step(); set_m1(1'b1, 4'hF, 32'h10, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        check("m1wr_gnt",  32'(m1_gnt),    1);
        check("m1wr_m0",   32'(m0_gnt),    0);
        check("m1wr_addr", 32'(bram_addr), 4);

        // Contention: both ports read continuously, pointer favours port 0
        step(); set_m0(1'b1, 4'h0, 32'h0C, 32'h0); set_m1(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_m0_gnt",    32'(m0_gnt),    32'(i % 2 == 0));
            check("rr_m1_gnt",    32'(m1_gnt),    32'(i % 2 == 1));
            check("rr_m0_rvalid", 32'(m0_rvalid), 32'(i % 2 == 1));
            check("rr_m1_rvalid", 32'(m1_rvalid), 32'(i > 0 && i % 2 == 0));
            if (i % 2 == 1) check("rr_m0_rdata", m0_rdata, 32'hDEADBEEF);
            else if (i > 0) check("rr_m1_rdata", m1_rdata, 32'hCAFEF00D);
            step();
        end
        set_m0(1'b0, 4'h0, 32'h0, 32'h0); set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("rr_tail_m1_rvalid", 32'(m1_rvalid), 1);
        check("rr_tail_m0_rvalid", 32'(m0_rvalid), 0);
        check("rr_tail_m1_rdata",  m1_rdata,       32'hCAFEF00D);

        // Lock burst with port 0 waiting, then lock released
        step(); set_m0(1'b1, 4'h0, 32'h0C, 32'h0); set_m1(1'b1, 4'h0, 32'h10, 32'h0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check($sformatf("lock_gnt_c%0d", i), 32'({m1_gnt, m0_gnt}), 32'(lock_exp[i]));
            step();
            if (i == 10) m1_lock = 1'b0;
        end
        set_m0(1'b0, 4'h0, 32'h0, 32'h0); set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        step();

        // Partial-lane write from port 1
        set_m1(1'b1, 4'h3, 32'h0C, 32'h12345678, 1'b0);
        @(negedge clk);
        check("lane_m1_gnt", 32'(m1_gnt),  1);
        check("lane_we",     32'(bram_we), 32'h3);
        step(); set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0); set_m0(1'b1, 4'h0, 32'h0C, 32'h0);
        @(negedge clk);
        check("lane_rd_gnt", 32'(m0_gnt), 1);
        step(); set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("lane_rvalid", 32'(m0_rvalid), 1);
        check("lane_rdata",  m0_rdata,       32'hDEAD5678);

        // Range boundary: top word in range, next byte address out of range
        step(); set_m0(1'b1, 4'hF, 32'h7C, 32'h55AA55AA);
        @(negedge clk);
        check("top_err",  32'(m0_err),    0);
        check("top_en",   32'(bram_en),   1);
        check("top_addr", 32'(bram_addr), 31);
        step(); set_m0(1'b1, 4'hF, 32'h80, 32'hFFFFFFFF);
        @(negedge clk);
        check("oor_wr_gnt", 32'(m0_gnt),  1);
        check("oor_wr_err", 32'(m0_err),  1);
        check("oor_wr_en",  32'(bram_en), 0);
        check("oor_wr_we",  32'(bram_we), 0);
        step(); set_m0(1'b1, 4'h0, 32'h00, 32'h0);
        @(negedge clk);
        check("w0_rd_gnt", 32'(m0_gnt), 1);
        step(); set_m0(1'b1, 4'h0, 32'h7C, 32'h0);
        @(negedge clk);
        check("w0_rdata",  m0_rdata, 32'h0);
        check("top_rd_en", 32'(bram_en), 1);

        // Port-1 out-of-range read while port 0's read data returns
        step(); set_m0(1'b0, 4'h0, 32'h0, 32'h0); set_m1(1'b1, 4'h0, 32'h100, 32'h0, 1'b0);
        @(negedge clk);
        check("top_rdata",  m0_rdata,       32'h55AA55AA);
        check("oor_m1_gnt", 32'(m1_gnt),    1);
        check("oor_m1_err", 32'(m1_err),    1);
        check("oor_m0_err", 32'(m0_err),    0);
        check("oor_en",     32'(bram_en),   0);
        step(); set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("oor_m1_rvalid", 32'(m1_rvalid), 1);
        check("oor_m1_rdata",  m1_rdata,       32'h0);
        check("oor_m0_rvalid", 32'(m0_rvalid), 0);

        // Reset in the cycle after a read grant
        step(); set_m0(1'b1, 4'h0, 32'h0C, 32'h0);
        @(negedge clk);
        check("mid_gnt", 32'(m0_gnt), 1);
        step(); rst = 1'b1; set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("mid_rst_rvalid", 32'(m0_rvalid), 0);
        step(); rst = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid", 32'(m0_rvalid), 0);
        check("post_rst_rdata0", m0_rdata,       32'h0);
        check("post_rst_rdata1", m1_rdata,       32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
